// File: rtl/iq_capture_ring_pkg.sv
// Shared types for the triggered I/Q capture ring: capture and read-port state encodings
// plus read response codes.
package iq_capture_ring_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StPost,
      StDone
   } cap_state_e;

   // RdOff keeps s_axi_rready low for the first cycle after reset release.
   typedef enum logic [1:0] {
      RdOff,
      RdIdle,
      RdWait,
      RdResp
   } rd_state_e;

   localparam logic RrespOk  = 1'b0;
   localparam logic RrespErr = 1'b1;

endpackage

// File: rtl/iq_capture_ring_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset.
module iq_capture_ring_ram #(
   parameter int unsigned WIDTH     = 48,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port share one clock.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/iq_capture_ring.sv
// Triggered multi-channel I/Q capture buffer. Streams all channels into a circular RAM while
// armed, freezes after the trigger with PRE_TRIGGER samples of history, then serves single
// reads addressed relative to the oldest retained pre-trigger sample.
module iq_capture_ring
   import iq_capture_ring_pkg::*;
#(
   parameter int unsigned BUFFER_LENGTH = 1024,
   parameter int unsigned INDEX_BITS    = 10,
   parameter int unsigned I_BITS        = 12,
   parameter int unsigned Q_BITS        = 12,
   parameter int unsigned NUM_CHANNELS  = 2,
   parameter int unsigned CH_BITS       = 1,
   parameter int unsigned PRE_TRIGGER   = 256
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    s_iq_valid,
   input  logic [NUM_CHANNELS*(I_BITS+Q_BITS)-1:0] s_iq_data,
   input  logic                                    arm,
   input  logic                                    trigger,
   output logic                                    armed,
   output logic                                    capturing,
   output logic                                    done,
   output logic [INDEX_BITS-1:0]                   trig_index,
   input  logic                                    m_axi_rvalid,
   input  logic [INDEX_BITS-1:0]                   m_axi_raddr,
   input  logic [CH_BITS-1:0]                      m_axi_rch,
   output logic                                    s_axi_rready,
   output logic signed [I_BITS-1:0]                i,
   output logic signed [Q_BITS-1:0]                q,
   output logic                                    s_axi_rvalid,
   output logic                                    s_axi_rresp,
   input  logic                                    m_axi_rready
);

   localparam int unsigned SAMPLE_BITS = I_BITS + Q_BITS;
   localparam int unsigned WORD_BITS   = NUM_CHANNELS * SAMPLE_BITS;
   localparam int unsigned POST_LEN    = BUFFER_LENGTH - PRE_TRIGGER;

   // ---------------------------------------------------------------- capture control
   cap_state_e            state_q, state_d;
   logic [INDEX_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [INDEX_BITS-1:0] pre_cnt_q, pre_cnt_d;
   logic [INDEX_BITS:0]   post_cnt_q, post_cnt_d;
   logic [INDEX_BITS-1:0] trig_index_q, trig_index_d;
   logic [INDEX_BITS-1:0] wr_ptr_inc;
   logic                  ram_we;

   assign wr_ptr_inc = (wr_ptr_q == INDEX_BITS'(BUFFER_LENGTH - 1)) ? '0 : wr_ptr_q + 1'b1;

   // Capture next-state: arm restarts from any state and wins over a coincident trigger.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      pre_cnt_d    = pre_cnt_q;
      post_cnt_d   = post_cnt_q;
      trig_index_d = trig_index_q;
      ram_we       = 1'b0;
      if (arm) begin
         state_d    = StArmed;
         wr_ptr_d   = '0;
         pre_cnt_d  = '0;
         post_cnt_d = '0;
      end else begin
         unique case (state_q)
            StArmed: begin
               if (s_iq_valid) begin
                  ram_we   = 1'b1;
                  wr_ptr_d = wr_ptr_inc;
                  if (pre_cnt_q != INDEX_BITS'(PRE_TRIGGER)) begin
                     pre_cnt_d = pre_cnt_q + 1'b1;
                  end
                  // Early triggers are dropped, not remembered.
                  if (trigger && (pre_cnt_q == INDEX_BITS'(PRE_TRIGGER))) begin
                     trig_index_d = wr_ptr_q;
                     post_cnt_d   = (INDEX_BITS+1)'(1);
                     state_d      = (POST_LEN == 1) ? StDone : StPost;
                  end
               end
            end
            StPost: begin
               if (s_iq_valid) begin
                  ram_we     = 1'b1;
                  wr_ptr_d   = wr_ptr_inc;
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (post_cnt_d == (INDEX_BITS+1)'(POST_LEN)) begin
                     state_d = StDone;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Capture state and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         pre_cnt_q    <= '0;
         post_cnt_q   <= '0;
         trig_index_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         pre_cnt_q    <= pre_cnt_d;
         post_cnt_q   <= post_cnt_d;
         trig_index_q <= trig_index_d;
      end
   end

   assign armed      = (state_q == StArmed);
   assign capturing  = (state_q == StPost);
   assign done       = (state_q == StDone);
   assign trig_index = trig_index_q;

   // ---------------------------------------------------------------- read port
   rd_state_e             rd_q, rd_d;
   logic                  accept;
   logic                  rd_err;
   logic [INDEX_BITS:0]   start_sum;
   logic [INDEX_BITS:0]   phys_sum;
   logic [INDEX_BITS-1:0] rd_phys;
   logic [WORD_BITS-1:0]  ram_rdata;
   logic [SAMPLE_BITS-1:0] chan_word;
   logic [CH_BITS-1:0]    rch_q;
   logic                  err_q;
   logic [I_BITS-1:0]     i_q;
   logic [Q_BITS-1:0]     q_q;
   logic                  resp_q;

   assign s_axi_rready = (rd_q == RdIdle);
   assign s_axi_rvalid = (rd_q == RdResp);
   assign accept       = m_axi_rvalid & s_axi_rready;

   // Logical-to-physical address: oldest kept sample sits PRE_TRIGGER before the trigger.
   always_comb begin
      start_sum = {1'b0, trig_index_q} + (INDEX_BITS+1)'(POST_LEN);
      if (start_sum >= (INDEX_BITS+1)'(BUFFER_LENGTH)) begin
         start_sum = start_sum - (INDEX_BITS+1)'(BUFFER_LENGTH);
      end
      phys_sum = start_sum + {1'b0, m_axi_raddr};
      if (phys_sum >= (INDEX_BITS+1)'(BUFFER_LENGTH)) begin
         phys_sum = phys_sum - (INDEX_BITS+1)'(BUFFER_LENGTH);
      end
      rd_err = (state_q != StDone) ||
               ({1'b0, m_axi_raddr} >= (INDEX_BITS+1)'(BUFFER_LENGTH)) ||
               ({1'b0, m_axi_rch} >= (CH_BITS+1)'(NUM_CHANNELS));
      // Errored requests still go through the RAM at a safe address to keep latency fixed.
      rd_phys = rd_err ? '0 : phys_sum[INDEX_BITS-1:0];
   end

   // Read handshake sequencing: idle -> RAM access -> response held until consumed.
   always_comb begin
      rd_d = rd_q;
      unique case (rd_q)
         RdOff:   rd_d = RdIdle;
         RdIdle:  if (m_axi_rvalid) rd_d = RdWait;
         RdWait:  rd_d = RdResp;
         RdResp:  if (m_axi_rready) rd_d = RdIdle;
         default: rd_d = RdOff;
      endcase
   end

   // Channel select after the RAM.
   always_comb begin
      chan_word = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (rch_q == CH_BITS'(c)) begin
            chan_word = ram_rdata[c*SAMPLE_BITS +: SAMPLE_BITS];
         end
      end
   end

   // Read-port state, request capture and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q   <= RdOff;
         rch_q  <= '0;
         err_q  <= 1'b0;
         i_q    <= '0;
         q_q    <= '0;
         resp_q <= RrespOk;
      end else begin
         rd_q <= rd_d;
         if (accept) begin
            rch_q <= m_axi_rch;
            err_q <= rd_err;
         end
         if (rd_q == RdWait) begin
            if (err_q) begin
               i_q    <= '0;
               q_q    <= '0;
               resp_q <= RrespErr;
            end else begin
               i_q    <= chan_word[SAMPLE_BITS-1:Q_BITS];
               q_q    <= chan_word[Q_BITS-1:0];
               resp_q <= RrespOk;
            end
         end
      end
   end

   assign i           = i_q;
   assign q           = q_q;
   assign s_axi_rresp = resp_q;

   iq_capture_ring_ram #(
      .WIDTH     (WORD_BITS),
      .DEPTH     (BUFFER_LENGTH),
      .ADDR_BITS (INDEX_BITS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr_q),
      .wdata (s_iq_data),
      .re    (accept),
      .raddr (rd_phys),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_iq_capture_ring.sv
// Bench for iq_capture_ring: hand-written capture scenarios, a table of directed reads and
// randomized captures checked against a sample-history model of the capture rules.
module tb_iq_capture_ring;

   localparam int BL = 16;
   localparam int PT = 4;
   localparam int NC = 2;
   localparam int IB = 5;
   localparam int CB = 1;
   localparam int SW = 24;
   localparam int DW = NC * SW;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 s_iq_valid;
   logic [DW-1:0]        s_iq_data;
   logic                 arm;
   logic                 trigger;
   logic                 armed;
   logic                 capturing;
   logic                 done;
   logic [IB-1:0]        trig_index;
   logic                 m_axi_rvalid;
   logic [IB-1:0]        m_axi_raddr;
   logic [CB-1:0]        m_axi_rch;
   logic                 s_axi_rready;
   logic signed [11:0]   i_out;
   logic signed [11:0]   q_out;
   logic                 s_axi_rvalid;
   logic                 s_axi_rresp;
   logic                 m_axi_rready;

   iq_capture_ring #(
      .BUFFER_LENGTH (BL),
      .INDEX_BITS    (IB),
      .I_BITS        (12),
      .Q_BITS        (12),
      .NUM_CHANNELS  (NC),
      .CH_BITS       (CB),
      .PRE_TRIGGER   (PT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_iq_valid   (s_iq_valid),
      .s_iq_data    (s_iq_data),
      .arm          (arm),
      .trigger      (trigger),
      .armed        (armed),
      .capturing    (capturing),
      .done         (done),
      .trig_index   (trig_index),
      .m_axi_rvalid (m_axi_rvalid),
      .m_axi_raddr  (m_axi_raddr),
      .m_axi_rch    (m_axi_rch),
      .s_axi_rready (s_axi_rready),
      .i            (i_out),
      .q            (q_out),
      .s_axi_rvalid (s_axi_rvalid),
      .s_axi_rresp  (s_axi_rresp),
      .m_axi_rready (m_axi_rready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: every sample taken since the last arm, in arrival order.
   logic [DW-1:0] hist[$];
   int            m_st;     // 0 idle, 1 waiting for trigger, 2 post-trigger, 3 frozen
   int            m_tpos;   // index of the trigger sample in hist
   logic [IB-1:0] m_tidx;

   typedef struct {
      int         ra;
      int         ch;
      logic       resp;
      logic [11:0] ei;
      logic [11:0] eq;
   } rd_vec_t;

   rd_vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ch c occupies bits [(c+1)*24-1 : c*24], I high; ch1 = ch0 + 100.
   function automatic logic [DW-1:0] ramp(input int v);
      logic [11:0] i0, q0, i1, q1;
      i0 = 12'(v);
      q0 = 12'(v + 1);
      i1 = 12'(v + 100);
      q1 = 12'(v + 101);
      return {i1, q1, i0, q0};
   endfunction

   task automatic model_reset();
      hist.delete();
      m_st   = 0;
      m_tpos = 0;
      m_tidx = '0;
   endtask

   task automatic model_edge(input bit a, input bit v, input bit t, input logic [DW-1:0] d);
      if (a) begin
         hist.delete();
         m_st = 1;
      end else if (v && (m_st == 1 || m_st == 2)) begin
         if (m_st == 1 && t && hist.size() >= PT) begin
            m_tpos = hist.size();
            m_tidx = IB'(m_tpos % BL);
            m_st   = 2;
         end
         hist.push_back(d);
         if (m_st == 2 && hist.size() - m_tpos == BL - PT) m_st = 3;
      end
   endtask

   task automatic model_read(input int ra, input int ch, output logic resp,
                             output logic [11:0] ei, output logic [11:0] eq);
      logic [DW-1:0] w;
      logic [SW-1:0] s;
      if (m_st != 3 || ra >= BL || ch >= NC) begin
         resp = 1'b1;
         ei   = '0;
         eq   = '0;
      end else begin
         w    = hist[m_tpos - PT + ra];
         s    = w[ch*SW +: SW];
         resp = 1'b0;
         ei   = s[23:12];
         eq   = s[11:0];
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, " armed"}, 32'(armed), 32'(m_st == 1));
      check({tag, " capturing"}, 32'(capturing), 32'(m_st == 2));
      check({tag, " done"}, 32'(done), 32'(m_st == 3));
      check({tag, " trig_index"}, 32'(trig_index), 32'(m_tidx));
   endtask

   // Entered and left just after a falling edge.
   task automatic step(input bit a, input bit v, input bit t, input logic [DW-1:0] d);
      arm        = a;
      s_iq_valid = v;
      trigger    = t;
      s_iq_data  = d;
      @(posedge clk);
      model_edge(a, v, t, d);
      @(negedge clk);
      arm        = 1'b0;
      s_iq_valid = 1'b0;
      trigger    = 1'b0;
      check_status("step");
   endtask

   task automatic do_read(input string name, input int ra, input int ch, input int hold,
                          input logic er, input logic [11:0] ei, input logic [11:0] eq);
      int k;
      k = 0;
      while (!s_axi_rready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({name, " rready before"}, 32'(s_axi_rready), 32'd1);
      m_axi_rvalid = 1'b1;
      m_axi_raddr  = IB'(ra);
      m_axi_rch    = CB'(ch);
      m_axi_rready = 1'b0;
      @(negedge clk);
      m_axi_rvalid = 1'b0;
      check({name, " rready after accept"}, 32'(s_axi_rready), 32'd0);
      check({name, " rvalid early"}, 32'(s_axi_rvalid), 32'd0);
      @(negedge clk);
      check({name, " rvalid"}, 32'(s_axi_rvalid), 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({name, " rvalid held"}, 32'(s_axi_rvalid), 32'd1);
         check({name, " rready held"}, 32'(s_axi_rready), 32'd0);
      end
      check({name, " rresp"}, 32'(s_axi_rresp), 32'(er));
      check({name, " i"}, {20'd0, i_out}, {20'd0, ei});
      check({name, " q"}, {20'd0, q_out}, {20'd0, eq});
      m_axi_rready = 1'b1;
      @(negedge clk);
      m_axi_rready = 1'b0;
      check({name, " rvalid drop"}, 32'(s_axi_rvalid), 32'd0);
      check({name, " rready back"}, 32'(s_axi_rready), 32'd1);
   endtask

   task automatic model_do_read(input string name, input int ra, input int ch, input int hold);
      logic        er;
      logic [11:0] ei, eq;
      model_read(ra, ch, er, ei, eq);
      do_read(name, ra, ch, hold, er, ei, eq);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      arm          = 1'b0;
      trigger      = 1'b0;
      s_iq_valid   = 1'b0;
      s_iq_data    = '0;
      m_axi_rvalid = 1'b0;
      m_axi_raddr  = '0;
      m_axi_rch    = '0;
      m_axi_rready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_status("reset");
      check("reset rready", 32'(s_axi_rready), 32'd0);
      check("reset rvalid", 32'(s_axi_rvalid), 32'd0);
      check("reset rresp", 32'(s_axi_rresp), 32'd0);
      check("reset i", {20'd0, i_out}, 32'd0);
      check("reset q", {20'd0, q_out}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("release rready", 32'(s_axi_rready), 32'd0);
      @(negedge clk);
      check("rready after release", 32'(s_axi_rready), 32'd1);
      check("armed after release", 32'(armed), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{ra: 0,  ch: 0, resp: 1'b0, ei: 12'd5,   eq: 12'd6};
      vecs[1] = '{ra: 4,  ch: 0, resp: 1'b0, ei: 12'd9,   eq: 12'd10};
      vecs[2] = '{ra: 15, ch: 0, resp: 1'b0, ei: 12'd20,  eq: 12'd21};
      vecs[3] = '{ra: 4,  ch: 1, resp: 1'b0, ei: 12'd109, eq: 12'd110};
      vecs[4] = '{ra: 0,  ch: 1, resp: 1'b0, ei: 12'd105, eq: 12'd106};
      vecs[5] = '{ra: 11, ch: 1, resp: 1'b0, ei: 12'd116, eq: 12'd117};
      vecs[6] = '{ra: 16, ch: 0, resp: 1'b1, ei: 12'd0,   eq: 12'd0};

      // Reset behaviour.
      do_reset();

      // Basic capture, trigger on sample 9.
      step(1, 0, 0, '0);
      for (int v = 0; v <= 20; v++) begin
         if (v == 20) check("done before last sample", 32'(done), 32'd0);
         step(0, 1, v == 9, ramp(v));
      end
      check("t2 trig_index", 32'(trig_index), 32'd9);
      check("t2 done", 32'(done), 32'd1);
      // Frozen buffer ignores further samples and triggers.
      step(0, 1, 1, ramp(99));
      for (int n = 0; n < 7; n++) begin
         do_read("t2 vec", vecs[n].ra, vecs[n].ch, n % 2, vecs[n].resp, vecs[n].ei, vecs[n].eq);
      end

      // Early trigger ignored, later one accepted.
      step(1, 0, 0, '0);
      for (int v = 0; v <= 17; v++) step(0, 1, (v == 2) || (v == 6), ramp(v));
      check("t3 trig_index", 32'(trig_index), 32'd6);
      check("t3 done", 32'(done), 32'd1);
      do_read("t3 raddr0", 0, 0, 0, 1'b0, 12'd2, 12'd3);

      // Pointer wrap before trigger.
      step(1, 0, 0, '0);
      for (int v = 0; v <= 41; v++) step(0, 1, v == 30, ramp(v));
      check("t4 trig_index", 32'(trig_index), 32'd14);
      do_read("t4 raddr0", 0, 0, 0, 1'b0, 12'd26, 12'd27);
      do_read("t4 raddr15", 15, 0, 0, 1'b0, 12'd41, 12'd42);

      // Read while armed is an error.
      step(1, 0, 0, '0);
      for (int v = 0; v < 3; v++) step(0, 1, 0, ramp(200 + v));
      do_read("t5 armed read", 3, 0, 0, 1'b1, 12'd0, 12'd0);

      // Back-pressure on read data, with arm+trigger in the same cycle.
      step(0, 1, 0, ramp(203));
      step(0, 1, 0, ramp(204));
      arm = 1'b1;
      trigger = 1'b1;
      s_iq_valid = 1'b1;
      s_iq_data = ramp(205);
      @(posedge clk);
      model_edge(1, 1, 1, ramp(205));
      @(negedge clk);
      arm = 1'b0; trigger = 1'b0; s_iq_valid = 1'b0;
      check("arm beats trigger armed", 32'(armed), 32'd1);
      for (int v = 0; v < 20; v++) step(0, 1, v == 7, ramp(300 + v));
      check("t6 done", 32'(done), 32'd1);
      model_do_read("t6 hold3", 2, 1, 3);

      // Reset mid-POST with a read in flight.
      step(1, 0, 0, '0);
      for (int v = 0; v < 6; v++) step(0, 1, v == 5, ramp(400 + v));
      check("t6 capturing", 32'(capturing), 32'd1);
      m_axi_rvalid = 1'b1;
      m_axi_raddr  = '0;
      @(negedge clk);
      m_axi_rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midreset capturing", 32'(capturing), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset rvalid", 32'(s_axi_rvalid), 32'd0);
      repeat (2) @(negedge clk);
      check("midreset rvalid later", 32'(s_axi_rvalid), 32'd0);
      do_reset();

      // Randomized captures against the history model.
      for (int r = 0; r < 6; r++) begin
         step(1, 0, 0, '0);
         for (int k = 0; k < 80 && m_st != 3; k++) begin
            step(($urandom % 50) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                 DW'({$urandom, $urandom}));
         end
         for (int n = 0; n < 6; n++) begin
            model_do_read("rand read", int'($urandom_range(0, BL + 1)),
                          int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 2)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
